// File: rtl/epac_pkg.sv
// Shared definitions for the SRAM arbiter clients: bus widths and the CCD writer state encoding.
package epac_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } ccd_wr_state_t;

endpackage

// File: rtl/ccd_sram_writer_if.sv
// CCD write-request port between the pixel writer and the SRAM arbiter.
interface ccd_sram_writer_if import epac_pkg::*; #(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              rd_nwr;
  logic              valid;
  logic              grant;

  modport master (output addr, output data, output rd_nwr, output valid, input grant);
  modport slave  (input addr, input data, input rd_nwr, input valid, output grant);

endinterface

// File: rtl/ccd_wr_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is legal when the head pops in the same cycle.
module ccd_wr_fifo import epac_pkg::*; #(
  parameter int WIDTH = SRAM_ADDR_W + SRAM_DATA_W,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             last
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   used;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign used  = wr_ptr_q - rd_ptr_q;
  assign empty = (used == '0);
  assign full  = (used == (PTR_W+1)'(DEPTH));
  assign last  = (used == (PTR_W+1)'(1));
  assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[PTR_W-1:0]] = wdata;
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ccd_sram_writer.sv
// CCD pixel stream to SRAM write requests: buffers pixels with their frame address and retires one per grant.
module ccd_sram_writer import epac_pkg::*; #(
  parameter int DATA_W      = SRAM_DATA_W,
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_WORDS = 76800,
  parameter int BASE_ADDR   = 0
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iFrame_start,
  input  logic                iPix_valid,
  input  logic [DATA_W-1:0]   iPix_data,
  ccd_sram_writer_if.master   sram,
  output logic                oBusy,
  output logic                oFrame_done,
  output logic                oOverflow,
  output logic [ADDR_W-1:0]   oPix_count
);

  localparam int                ENTRY_W    = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] FRAME_LAST = ADDR_W'(FRAME_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);

  ccd_wr_state_t      state_q, state_d;
  logic [ADDR_W-1:0]  pix_count_q, pix_count_d;
  logic               overflow_q, overflow_d;
  logic               frame_done_q, frame_done_d;

  logic               fifo_empty, fifo_full, fifo_last;
  logic [ENTRY_W-1:0] fifo_head;
  logic               pix_take, push, pop;

  // Valid depends only on FIFO state so the arbiter's grant never loops back into it.
  assign pix_take = iPix_valid && (state_q == CAPTURE);
  assign pop      = !fifo_empty && sram.grant;
  assign push     = pix_take && (!fifo_full || pop);

  ccd_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (push),
    .pop   (pop),
    .wdata ({BASE + pix_count_q, iPix_data}),
    .head  (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .last  (fifo_last)
  );

  assign sram.valid             = !fifo_empty;
  assign {sram.addr, sram.data} = fifo_head;
  assign sram.rd_nwr            = 1'b0;

  assign oBusy       = (state_q != IDLE);
  assign oFrame_done = frame_done_q;
  assign oOverflow   = overflow_q;
  assign oPix_count  = pix_count_q;

  always_comb begin
    state_d      = state_q;
    pix_count_d  = pix_count_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (iFrame_start) begin
          state_d     = CAPTURE;
          pix_count_d = '0;
          overflow_d  = 1'b0;
        end
      end
      CAPTURE: begin
        // Dropped pixels still advance the count so later pixels land at their true address.
        if (iPix_valid) begin
          pix_count_d = pix_count_q + ADDR_W'(1);
          if (fifo_full && !pop) overflow_d = 1'b1;
          if (pix_count_q == FRAME_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty || (pop && fifo_last)) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= IDLE;
      pix_count_q  <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_count_q  <= pix_count_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
